alu_cmd_issue: RTL

Command-issue stage placed directly upstream of the 32-bit, 4-bit-opcode ALU. It buffers incoming operation commands (ctrl, a, b, c) in a small FIFO and presents the head command to the combinational ALU. It captures the ALU result `d` into an output register. A valid/ready handshake on each side lets producers and consumers stall independently, at a sustained rate of one operation per clock.

---
 rtl/alu_cmd_issue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue
// Command-issue stage in front of a 32-bit combinational ALU.
// Operation commands {ctrl, a, b, c} are buffered in a DEPTH-entry FIFO.
// The FIFO head is presented to the ALU, and the ALU result is captured
// into a result register that has a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of FIFO occupancy, result valid, counter
//   cmd_valid/ready   command-side handshake (ready = count < DEPTH)
//   cmd_ctrl/a/b/c    incoming command fields
//   alu_ctrl/a/b/c    head entry to the ALU, zero when the FIFO is empty
//   alu_d             combinational ALU result for the alu_* values
//   res_valid/ready   result-side handshake
//   res_data/ctrl     captured ALU result and the opcode that produced it
//   fifo_count        current FIFO occupancy
//   issued_cnt        results captured since reset/flush (wrapping)
module alu_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_ctrl,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [31:0]              cmd_c,
    output logic [3:0]               alu_ctrl,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [31:0]              alu_c,
    input  logic [31:0]              alu_d,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [3:0]               res_ctrl,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issued_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    // Command storage. Not reset and not cleared by flush: occupancy is
    // tracked by count_reg, so stale contents are never observed.
    logic [3:0]  mem_ctrl [DEPTH];
    logic [31:0] mem_a    [DEPTH];
    logic [31:0] mem_b    [DEPTH];
    logic [31:0] mem_c    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             res_valid_reg, res_valid_next;
    logic [31:0]      res_data_reg, res_data_next;
    logic [3:0]       res_ctrl_reg, res_ctrl_next;
    logic [CNT_W-1:0] issued_cnt_reg, issued_cnt_next;

    logic fifo_empty;
    logic push;
    logic issue;

    assign fifo_empty = (count_reg == '0);
    // Ready looks only at the registered count; it deliberately does not
    // anticipate a same-cycle pop, keeping cmd_ready free of res_ready paths.
    assign cmd_ready  = (count_reg < CW'(DEPTH));

    assign push  = cmd_valid && cmd_ready && !flush;
    assign issue = !fifo_empty && (!res_valid_reg || res_ready) && !flush;

    // Head drive, forced to zero while empty so the ALU sees a quiet input.
    assign alu_ctrl = fifo_empty ? 4'd0  : mem_ctrl[rd_ptr_reg];
    assign alu_a    = fifo_empty ? 32'd0 : mem_a[rd_ptr_reg];
    assign alu_b    = fifo_empty ? 32'd0 : mem_b[rd_ptr_reg];
    assign alu_c    = fifo_empty ? 32'd0 : mem_c[rd_ptr_reg];

    // Per-entry write enables decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_ctrl[gi] <= cmd_ctrl;
                    mem_a[gi]    <= cmd_a;
                    mem_b[gi]    <= cmd_b;
                    mem_c[gi]    <= cmd_c;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        res_valid_next  = res_valid_reg;
        res_data_next   = res_data_reg;
        res_ctrl_next   = res_ctrl_reg;
        issued_cnt_next = issued_cnt_reg;

        if (flush) begin
            // Result payload is kept; only its valid flag is dropped.
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            count_next      = '0;
            res_valid_next  = 1'b0;
            issued_cnt_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr_next     = rd_ptr_reg + PTR_W'(1);
                res_valid_next  = 1'b1;
                res_data_next   = alu_d;
                res_ctrl_next   = alu_ctrl;
                issued_cnt_next = issued_cnt_reg + CNT_W'(1);
            end else if (res_ready) begin
                // Consumer took the result and nothing replaces it.
                res_valid_next = 1'b0;
            end
            case ({push, issue})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_ctrl_reg   <= '0;
            issued_cnt_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            res_valid_reg  <= res_valid_next;
            res_data_reg   <= res_data_next;
            res_ctrl_reg   <= res_ctrl_next;
            issued_cnt_reg <= issued_cnt_next;
        end
    end

    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_ctrl   = res_ctrl_reg;
    assign fifo_count = count_reg;
    assign issued_cnt = issued_cnt_reg;

endmodule
